// File: rtl/commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// commit_trace_buffer
//
// Purpose:
//    Hardware commit monitor for the pipelined CPU. Every cycle it samples the
//    writeback and memory-stage commit signals. Each retired event is
//    classified (OTHER/REG/LD/ST/HALT), tagged with a sequence number and
//    pushed into a FIFO. A debug port drains the FIFO with a valid/ready
//    handshake. The block also keeps cycle and instruction counters, a
//    watchdog timeout and a sticky overflow flag.
//
// Ports:
//    clk, rst_n           clock, synchronous active-low reset
//    cap_en               capture enable; capture and counters freeze while 0
//    pc                   PC of the committing instruction
//    wb_regwrite/wb_dst/wb_data        writeback commit
//    mem_read/mem_write/mem_addr/mem_wdata  memory-stage commit
//    halt                 halt committed
//    rec_valid/rec_ready  FIFO head handshake
//    rec_type/rec_inum/rec_pc/rec_value/rec_addr/rec_reg  FIFO head record
//    cycle_count, inst_count  statistics (saturating)
//    overflow, timeout, stopped, done  status flags
// -----------------------------------------------------------------------------
module commit_trace_buffer #(
   parameter int DATA_W      = 16,
   parameter int REG_W       = 4,
   parameter int DEPTH       = 16,
   parameter int CNT_W       = 32,
   parameter int CYCLE_LIMIT = 100000,
   parameter int SKIP_IDLE   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cap_en,
   input  logic [DATA_W-1:0] pc,
   input  logic              wb_regwrite,
   input  logic [REG_W-1:0]  wb_dst,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [DATA_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              halt,
   output logic              rec_valid,
   input  logic              rec_ready,
   output logic [2:0]        rec_type,
   output logic [CNT_W-1:0]  rec_inum,
   output logic [DATA_W-1:0] rec_pc,
   output logic [DATA_W-1:0] rec_value,
   output logic [DATA_W-1:0] rec_addr,
   output logic [REG_W-1:0]  rec_reg,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  inst_count,
   output logic              overflow,
   output logic              timeout,
   output logic              stopped,
   output logic              done
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FCNT_W = $clog2(DEPTH + 1);
   localparam int REC_W  = 3 + CNT_W + 3 * DATA_W + REG_W;

   localparam logic [PTR_W-1:0]  PTR_ONE   = 1;
   localparam logic [FCNT_W-1:0] FCNT_ONE  = 1;
   localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ONE   = 1;
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]  LIMIT_M1  = CNT_W'(CYCLE_LIMIT - 1);

   localparam logic [2:0] T_OTHER = 3'd0;
   localparam logic [2:0] T_REG   = 3'd1;
   localparam logic [2:0] T_LD    = 3'd2;
   localparam logic [2:0] T_ST    = 3'd3;
   localparam logic [2:0] T_HALT  = 3'd4;

   // FIFO storage and state
   logic [REC_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [FCNT_W-1:0] r_count;

   logic [CNT_W-1:0]  r_cycle_count;
   logic [CNT_W-1:0]  r_inst_count;
   logic              r_overflow;
   logic              r_timeout;
   logic              r_stopped;

   // Classified event
   logic [2:0]        w_type;
   logic [DATA_W-1:0] w_value;
   logic [DATA_W-1:0] w_addr;
   logic [REG_W-1:0]  w_reg;
   logic [REC_W-1:0]  w_rec;

   logic w_active;
   logic w_record;
   logic w_pop;
   logic w_push;
   logic w_limit_hit;

   // Fixed-priority classification; unused record fields are forced to zero.
   always_comb begin
      w_type  = T_OTHER;
      w_value = '0;
      w_addr  = '0;
      w_reg   = '0;
      if (wb_regwrite && mem_read) begin
         w_type  = T_LD;
         w_value = wb_data;
         w_addr  = mem_addr;
         w_reg   = wb_dst;
      end else if (wb_regwrite) begin
         w_type  = T_REG;
         w_value = wb_data;
         w_reg   = wb_dst;
      end else if (halt) begin
         w_type  = T_HALT;
      end else if (mem_write && !mem_read) begin
         w_type  = T_ST;
         w_value = mem_wdata;
         w_addr  = mem_addr;
      end
   end

   assign w_rec = {w_type, r_inst_count, pc, w_value, w_addr, w_reg};

   assign w_active    = cap_en && !r_stopped;
   assign w_record    = w_active && ((w_type != T_OTHER) || (SKIP_IDLE == 0));
   assign w_pop       = (r_count != '0) && rec_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push      = w_record && ((r_count != FCNT_FULL) || w_pop);
   assign w_limit_hit = w_active && (r_cycle_count >= LIMIT_M1);

   // Storage is not reset; r_count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_rec;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_cycle_count <= '0;
         r_inst_count  <= '0;
         r_overflow    <= 1'b0;
         r_timeout     <= 1'b0;
         r_stopped     <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + FCNT_ONE;
            2'b01:   r_count <= r_count - FCNT_ONE;
            default: r_count <= r_count;
         endcase

         if (w_active && (r_cycle_count != CNT_MAX)) begin
            r_cycle_count <= r_cycle_count + CNT_ONE;
         end
         // Dropped records still consume a sequence number so the gap shows.
         if (w_record && (r_inst_count != CNT_MAX)) begin
            r_inst_count <= r_inst_count + CNT_ONE;
         end
         if (w_record && !w_push) begin
            r_overflow <= 1'b1;
         end
         if (w_limit_hit) begin
            r_timeout <= 1'b1;
            r_stopped <= 1'b1;
         end
         if (w_record && (w_type == T_HALT)) begin
            r_stopped <= 1'b1;
         end
      end
   end

   assign rec_valid = (r_count != '0);
   assign {rec_type, rec_inum, rec_pc, rec_value, rec_addr, rec_reg} = r_mem[r_rd_ptr];

   assign cycle_count = r_cycle_count;
   assign inst_count  = r_inst_count;
   assign overflow    = r_overflow;
   assign timeout     = r_timeout;
   assign stopped     = r_stopped;
   assign done        = r_stopped && !rec_valid;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_commit_trace_buffer
//
// Directed bench for commit_trace_buffer. A main instance (DEPTH=8) covers
// classification, draining, overflow, full push+pop and reset; a second
// instance (CYCLE_LIMIT=20, SKIP_IDLE=1) covers the watchdog with idle input.
// -----------------------------------------------------------------------------
module tb_commit_trace_buffer;

   localparam int D = 8;

   logic        clk;
   logic        rst_n;
   logic        cap_en;
   logic [15:0] pc;
   logic        wb_regwrite;
   logic [3:0]  wb_dst;
   logic [15:0] wb_data;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        halt;
   logic        rec_ready;
   logic        rec_valid;
   logic [2:0]  rec_type;
   logic [31:0] rec_inum;
   logic [15:0] rec_pc;
   logic [15:0] rec_value;
   logic [15:0] rec_addr;
   logic [3:0]  rec_reg;
   logic [31:0] cycle_count;
   logic [31:0] inst_count;
   logic        overflow;
   logic        timeout;
   logic        stopped;
   logic        done;

   // Watchdog instance signals
   logic        t_rst_n;
   logic        t_cap_en;
   logic        z1;
   logic [3:0]  z4;
   logic [15:0] z16;
   logic        t_rec_valid;
   logic [2:0]  t_rec_type;
   logic [31:0] t_rec_inum;
   logic [15:0] t_rec_pc;
   logic [15:0] t_rec_value;
   logic [15:0] t_rec_addr;
   logic [3:0]  t_rec_reg;
   logic [31:0] t_cycle_count;
   logic [31:0] t_inst_count;
   logic        t_overflow;
   logic        t_timeout;
   logic        t_stopped;
   logic        t_done;

   int n_checks = 0;
   int n_errors = 0;

   commit_trace_buffer #(
      .DATA_W(16), .REG_W(4), .DEPTH(D), .CNT_W(32),
      .CYCLE_LIMIT(100000), .SKIP_IDLE(0)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .pc(pc),
      .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_data(wb_data),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .halt(halt),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_type(rec_type),
      .rec_inum(rec_inum), .rec_pc(rec_pc), .rec_value(rec_value),
      .rec_addr(rec_addr), .rec_reg(rec_reg),
      .cycle_count(cycle_count), .inst_count(inst_count),
      .overflow(overflow), .timeout(timeout), .stopped(stopped), .done(done)
   );

   commit_trace_buffer #(
      .DATA_W(16), .REG_W(4), .DEPTH(4), .CNT_W(32),
      .CYCLE_LIMIT(20), .SKIP_IDLE(1)
   ) u_dut_wd (
      .clk(clk), .rst_n(t_rst_n), .cap_en(t_cap_en), .pc(z16),
      .wb_regwrite(z1), .wb_dst(z4), .wb_data(z16),
      .mem_read(z1), .mem_write(z1), .mem_addr(z16),
      .mem_wdata(z16), .halt(z1),
      .rec_valid(t_rec_valid), .rec_ready(z1), .rec_type(t_rec_type),
      .rec_inum(t_rec_inum), .rec_pc(t_rec_pc), .rec_value(t_rec_value),
      .rec_addr(t_rec_addr), .rec_reg(t_rec_reg),
      .cycle_count(t_cycle_count), .inst_count(t_inst_count),
      .overflow(t_overflow), .timeout(t_timeout), .stopped(t_stopped), .done(t_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      pc          = '0;
      wb_regwrite = 1'b0;
      wb_dst      = '0;
      wb_data     = '0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      halt        = 1'b0;
   endtask

   // One active cycle carrying the given commit, then capture is frozen again.
   task automatic ev(input logic rw, input logic mr, input logic mw, input logic hl,
                     input logic [3:0] dst, input logic [15:0] p, input logic [15:0] d,
                     input logic [15:0] a, input logic [15:0] wd);
      wb_regwrite = rw;
      mem_read    = mr;
      mem_write   = mw;
      halt        = hl;
      wb_dst      = dst;
      pc          = p;
      wb_data     = d;
      mem_addr    = a;
      mem_wdata   = wd;
      cap_en      = 1'b1;
      step();
      cap_en      = 1'b0;
      clear_in();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   // Check the FIFO head against an expected record, then pop it.
   task automatic pop_check(input string tag, input logic [2:0] t, input logic [31:0] inum,
                            input logic [15:0] p, input logic [15:0] v,
                            input logic [15:0] a, input logic [3:0] r);
      check_val({tag, "_valid"}, 64'(rec_valid), 64'd1);
      check_val({tag, "_type"},  64'(rec_type),  64'(t));
      check_val({tag, "_inum"},  64'(rec_inum),  64'(inum));
      check_val({tag, "_pc"},    64'(rec_pc),    64'(p));
      check_val({tag, "_value"}, 64'(rec_value), 64'(v));
      check_val({tag, "_addr"},  64'(rec_addr),  64'(a));
      check_val({tag, "_reg"},   64'(rec_reg),   64'(r));
      rec_ready = 1'b1;
      step();
      rec_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      cap_en    = 1'b0;
      rec_ready = 1'b0;
      clear_in();
      t_rst_n   = 1'b0;
      t_cap_en  = 1'b1;
      z1        = 1'b0;
      z4        = '0;
      z16       = '0;
      step();
      step();

      // Reset state
      check_val("rst_valid",    64'(rec_valid),   64'd0);
      check_val("rst_cycle",    64'(cycle_count), 64'd0);
      check_val("rst_inst",     64'(inst_count),  64'd0);
      check_val("rst_overflow", 64'(overflow),    64'd0);
      check_val("rst_timeout",  64'(timeout),     64'd0);
      check_val("rst_stopped",  64'(stopped),     64'd0);
      check_val("rst_done",     64'(done),        64'd0);
      rst_n = 1'b1;

      // Single REG event, visible one edge later
      ev(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 16'h0004, 16'hBEEF, 16'h0000, 16'h0000);
      check_val("reg_inst",  64'(inst_count),  64'd1);
      check_val("reg_cycle", 64'(cycle_count), 64'd1);
      pop_check("reg", 3'd1, 32'd0, 16'h0004, 16'hBEEF, 16'h0000, 4'd3);
      check_val("reg_empty", 64'(rec_valid), 64'd0);

      // LD, ST, HALT; then commits while stopped are ignored
      do_reset();
      ev(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 16'h0008, 16'h1234, 16'h0010, 16'h0000);
      ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 16'h000C, 16'h9999, 16'h0020, 16'h5678);
      ev(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
      check_val("halt_stopped", 64'(stopped),    64'd1);
      check_val("halt_done0",   64'(done),       64'd0);
      check_val("halt_inst",    64'(inst_count), 64'd3);
      ev(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'h0014, 16'h7777, 16'h0000, 16'h0000);
      check_val("frozen_inst",  64'(inst_count),  64'd3);
      check_val("frozen_cycle", 64'(cycle_count), 64'd3);
      pop_check("ld",   3'd2, 32'd0, 16'h0008, 16'h1234, 16'h0010, 4'd5);
      pop_check("st",   3'd3, 32'd1, 16'h000C, 16'h5678, 16'h0020, 4'd0);
      pop_check("halt", 3'd4, 32'd2, 16'h0010, 16'h0000, 16'h0000, 4'd0);
      check_val("halt_done1", 64'(done),      64'd1);
      check_val("halt_empty", 64'(rec_valid), 64'd0);

      // Overflow: D+2 REG events with no consumer
      do_reset();
      for (int i = 0; i < D + 2; i++) begin
         ev(1'b1, 1'b0, 1'b0, 1'b0, 4'(i), 16'(i * 4), 16'(16'h0100 + i), 16'h0, 16'h0);
         check_val($sformatf("ovf_flag%0d", i), 64'(overflow), 64'((i >= D) ? 1 : 0));
      end
      check_val("ovf_inst", 64'(inst_count), 64'(D + 2));
      for (int i = 0; i < D; i++) begin
         pop_check($sformatf("ovf_pop%0d", i), 3'd1, 32'(i), 16'(i * 4),
                   16'(16'h0100 + i), 16'h0000, 4'(i));
      end
      check_val("ovf_empty", 64'(rec_valid), 64'd0);

      // Full FIFO with push and pop in the same cycle
      do_reset();
      for (int i = 0; i < D; i++) begin
         ev(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 16'h0040, 16'(16'h0200 + i), 16'h0, 16'h0);
      end
      rec_ready = 1'b1;
      ev(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 16'h0040, 16'(16'h0200 + D), 16'h0, 16'h0);
      rec_ready = 1'b0;
      check_val("pp_overflow", 64'(overflow),   64'd0);
      check_val("pp_inst",     64'(inst_count), 64'(D + 1));
      for (int i = 1; i <= D; i++) begin
         pop_check($sformatf("pp_pop%0d", i), 3'd1, 32'(i), 16'h0040,
                   16'(16'h0200 + i), 16'h0000, 4'd2);
      end
      check_val("pp_empty", 64'(rec_valid), 64'd0);

      // Reset while records are pending
      do_reset();
      for (int i = 0; i < 5; i++) begin
         ev(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 16'h0080, 16'(i), 16'h0, 16'h0);
      end
      check_val("mid_valid_pre", 64'(rec_valid), 64'd1);
      do_reset();
      check_val("mid_valid",    64'(rec_valid),   64'd0);
      check_val("mid_cycle",    64'(cycle_count), 64'd0);
      check_val("mid_inst",     64'(inst_count),  64'd0);
      check_val("mid_overflow", 64'(overflow),    64'd0);
      check_val("mid_stopped",  64'(stopped),     64'd0);
      ev(1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 16'h0090, 16'hABCD, 16'h0, 16'h0);
      pop_check("mid_next", 3'd1, 32'd0, 16'h0090, 16'hABCD, 16'h0000, 4'd6);

      // Watchdog on the idle-only instance
      t_rst_n = 1'b1;
      repeat (19) step();
      check_val("wd_cycle19",   64'(t_cycle_count), 64'd19);
      check_val("wd_timeout19", 64'(t_timeout),     64'd0);
      step();
      check_val("wd_cycle",   64'(t_cycle_count), 64'd20);
      check_val("wd_timeout", 64'(t_timeout),     64'd1);
      check_val("wd_stopped", 64'(t_stopped),     64'd1);
      check_val("wd_done",    64'(t_done),        64'd1);
      check_val("wd_valid",   64'(t_rec_valid),   64'd0);
      check_val("wd_inst",    64'(t_inst_count),  64'd0);
      repeat (3) step();
      check_val("wd_cycle_hold", 64'(t_cycle_count), 64'd20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Synthesisable, parametrised commit monitor for the pipelined CPU that replaces simulation-only trace printing with hardware records. It sits beside the core and samples the writeback and memory-stage commit signals every cycle. Each retired event is classified as REG, LD, ST, OTHER or HALT, tagged with a sequence number and pushed into a FIFO that a debug port drains with a valid/ready handshake. It also keeps cycle and instruction counters, a watchdog timeout and a sticky overflow flag.

## Interface
- DATA_W, 16, data/PC/address width
- REG_W, 4, register-index width
- DEPTH, 16, FIFO entries; power of two, at least 2
- CNT_W, 32, counter and sequence-number width
- CYCLE_LIMIT, 100000, watchdog cycle limit
- SKIP_IDLE, 0, when 1, OTHER events are not recorded and do not advance inum
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cap_en  in  1  capture enable; counters and capture freeze while 0
- pc  in  DATA_W  PC of the committing instruction
- wb_regwrite  in  1  writeback register write
- wb_dst  in  REG_W  writeback destination register
- wb_data  in  DATA_W  writeback data
- mem_read  in  1  memory stage read
- mem_write  in  1  memory stage write
- mem_addr  in  DATA_W  memory address
- mem_wdata  in  DATA_W  store data
- halt  in  1  halt committed
- rec_valid  out  1  FIFO head valid
- rec_ready  in  1  consumer accepts head
- rec_type  out  3  0 OTHER, 1 REG, 2 LD, 3 ST, 4 HALT
- rec_inum  out  CNT_W  sequence number
- rec_pc, rec_value, rec_addr  out  DATA_W each  PC, reg/store value, memory address (0 when unused)
- rec_reg  out  REG_W  destination register (0 when unused)
- cycle_count, inst_count  out  CNT_W each  statistics
- overflow, timeout, stopped, done  out  1 each  status flags

## Operation
- Active cycle: rst_n=1, cap_en=1 and stopped=0. Nothing is captured or counted outside active cycles.
- Classification uses fixed priority:
  - wb_regwrite&mem_read gives LD: value=wb_data, addr=mem_addr.
  - wb_regwrite alone gives REG.
  - halt gives HALT.
  - mem_write&~mem_read gives ST: addr=mem_addr, value=mem_wdata.
  - Anything else gives OTHER.
- Each recorded event takes inum equal to the current inst_count, then inst_count increments by 1. OTHER is recorded only when SKIP_IDLE=0.
- cycle_count increments on every active cycle.
- FIFO push:
  - The push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the record is dropped, overflow sets (sticky) and inst_count still increments, so the gap is visible in inum.
- FIFO pop happens when rec_valid&rec_ready. Read and write pointers wrap modulo DEPTH. A separate count of 0..DEPTH distinguishes full from empty.
- A HALT record sets stopped on the next edge. If that HALT is dropped, stopped still sets.
- timeout sets and stopped sets when cycle_count reaches CYCLE_LIMIT-1 in an active cycle. The event sampled in that cycle is still recorded.
- done = stopped & ~rec_valid. Draining continues normally while stopped=1.
- Counters saturate at all ones and never wrap.
- Reset clears pointers, FIFO count, both counters and all flags. FIFO storage contents need not be cleared. Reset mid-drain discards every pending record.

## Timing
- Reset values: rec_valid=0, cycle_count=0, inst_count=0, overflow=0, timeout=0, stopped=0, done=0. rec_* data outputs are don't-care while rec_valid=0.
- Latency: an event sampled at edge N is visible on rec_* with rec_valid=1 after edge N when the FIFO was empty. There is no combinational path from any commit input to rec_*.
- rec_* data is held stable while rec_valid=1 and rec_ready=0.
- rec_ready may be asserted at any time. A pop with rec_valid=0 has no effect.
- The status flags, cycle_count and inst_count are registered and update one edge after their cause.
- With push and pop in the same cycle, the FIFO count is unchanged. When full, no overflow is flagged.

## Test plan
- Reset, then REG (pc=0x0004, dst=3, data=0xBEEF) -> one cycle later rec_type=1, rec_reg=3, rec_value=0xBEEF, rec_inum=0; inst_count=1.
- LD (regwrite+mem_read, addr=0x0010, data=0x1234), then ST (addr=0x0020, wdata=0x5678), then HALT -> records with types 2, 3, 4 and inum 0, 1, 2; stopped=1; after draining, done=1; later commit inputs are ignored.
- rec_ready=0 with DEPTH+2 REG events -> DEPTH records stored, overflow=1, inst_count=DEPTH+2; drained inum are 0..DEPTH-1.
- FIFO full with push and pop in the same cycle -> no overflow, count unchanged, inum sequence stays contiguous.
- CYCLE_LIMIT=20 with only idle cycles and SKIP_IDLE=1 -> no records, cycle_count=20, timeout=1, stopped=1, done=1.
- rst_n low for one cycle while 5 records are pending -> rec_valid=0, all counters and flags 0, and the next event gets inum=0.
